// File: rtl/lock_reg_bank.sv
// Lockable register bank with sticky per-register write locks, secure-scan clear
// and a two-word debug unlock sequence with a lockout penalty after a bad key.
module lock_reg_bank #(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 4,
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter logic [DATA_W-1:0] KEY0 = DATA_W'(16'hA5C3),
  parameter logic [DATA_W-1:0] KEY1 = DATA_W'(16'h3C5A),
  parameter int LOCKOUT_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                lock_wr,
  input  logic                lock_all,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                scan,
  input  logic                debug_mode,
  input  logic                dbg_key_vld,
  input  logic [DATA_W-1:0]   dbg_key,
  output logic                dbg_open,
  output logic                wr_err,
  output logic [7:0]          viol_cnt,
  output logic [NUM_REGS-1:0] lock_status
);

  typedef enum logic [1:0] {DBG_LOCKED, DBG_KEY1, DBG_OPEN, DBG_PENALTY} dbg_state_t;

  localparam int PEN_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  dbg_state_t          state;
  dbg_state_t          state_next;
  logic [PEN_W-1:0]    pen_cnt;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] lock_bits;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   rd_val;
  logic                scan_q;
  logic                scan_rise;
  logic                wr_hit;
  logic                wr_locked;
  logic                wr_accept;

  assign scan_rise = scan & ~scan_q;

  // Address decode doubles as the range check: out-of-range addresses select nothing.
  always_comb begin
    wr_sel = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_sel[i] = 1'b1;
      if (rd_addr == ADDR_W'(i)) rd_val = regs[i];
    end
  end

  assign wr_hit    = |wr_sel;
  assign wr_locked = |(wr_sel & lock_bits);
  assign wr_accept = wr_en & wr_hit & (~wr_locked | dbg_open);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (scan_rise) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i]) regs[i] <= wr_data;
    end
  end

  // Locks are qualified with their old value above, so a same-cycle lock lands after the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_bits <= '0;
      rd_data   <= '0;
      wr_err    <= 1'b0;
      viol_cnt  <= '0;
      scan_q    <= 1'b0;
    end else begin
      lock_bits <= lock_bits | {NUM_REGS{lock_all}} | (lock_wr ? wr_sel : '0);
      rd_data   <= rd_val;
      wr_err    <= wr_en & ~wr_accept;
      scan_q    <= scan;
      if (wr_en && !wr_accept && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
    end
  end

  assign lock_status = lock_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DBG_LOCKED;
      pen_cnt <= '0;
    end else begin
      state   <= state_next;
      pen_cnt <= (state == DBG_PENALTY) ? pen_cnt + PEN_W'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    if (scan_rise) begin
      state_next = DBG_LOCKED;
    end else begin
      case (state)
        DBG_LOCKED:
          if (debug_mode && dbg_key_vld)
            state_next = (dbg_key == KEY0) ? DBG_KEY1 : DBG_PENALTY;
        DBG_KEY1:
          if (!debug_mode) state_next = DBG_LOCKED;
          else if (dbg_key_vld) state_next = (dbg_key == KEY1) ? DBG_OPEN : DBG_PENALTY;
        DBG_OPEN:
          if (!debug_mode) state_next = DBG_LOCKED;
        DBG_PENALTY:
          if (pen_cnt == PEN_W'(LOCKOUT_CYC - 1)) state_next = DBG_LOCKED;
        default:
          state_next = DBG_LOCKED;
      endcase
    end
  end

  always_comb begin
    dbg_open = (state == DBG_OPEN);
  end

endmodule

// File: doc/lock_reg_bank.md
LOCK_REG_BANK -- requirements
Module: lock_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each data register.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of registers (1..16, need not be a power of 2); ADDR_W = max(1, clog2(NUM_REGS)).
REQ-003 SHALL have parameter KEY0 and KEY1, each DATA_W wide, defaults 16'hA5C3 and 16'h3C5A, the debug unlock key words.
REQ-004 SHALL have parameter LOCKOUT_CYC, default 8, the penalty cycles after a bad key.
REQ-005 Ports, in this order:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- wr_en, in, 1: data write strobe.
- wr_addr, in, ADDR_W: write/lock target.
- wr_data, in, DATA_W: write data.
- lock_wr, in, 1: set lock bit of wr_addr.
- lock_all, in, 1: set all lock bits.
- rd_addr, in, ADDR_W: read address.
- rd_data, out, DATA_W: registered read data.
- scan, in, 1: scan mode.
- debug_mode, in, 1: debug request.
- dbg_key_vld, in, 1: key word strobe.
- dbg_key, in, DATA_W: key word.
- dbg_open, out, 1: debug override active.
- wr_err, out, 1: one-cycle pulse on a rejected write.
- viol_cnt, out, 8: saturating count of rejected writes.
- lock_status, out, NUM_REGS: current lock bits.

Function
REQ-006 Lock bits SHALL be sticky: set by lock_wr (for wr_addr) or lock_all, and cleared only by reset.
REQ-007 A write SHALL be accepted when wr_en=1, wr_addr<NUM_REGS, and either (lock bit=0) or dbg_open=1; the register SHALL update at the next clk edge.
REQ-008 scan SHALL NOT override locks.
REQ-009 A write with wr_en=1 that is not accepted (locked without dbg_open, or address out of range) SHALL pulse wr_err for one cycle in the next cycle and increment viol_cnt, which saturates at 255.
REQ-010 If wr_en and lock_wr target the same address in the same cycle, the write SHALL be qualified against the old lock value and the lock SHALL set afterwards; the same applies to lock_all.
REQ-011 rd_data SHALL equal reg[rd_addr] one cycle after rd_addr is sampled (1-cycle latency) and SHALL be 0 for rd_addr>=NUM_REGS.
REQ-012 A write and a read to the same address in the same cycle SHALL return the old value.
REQ-013 Secure scan: in the cycle after a 0->1 transition of scan is sampled, all data registers SHALL clear to 0; this clear SHALL take priority over any write in that cycle; lock bits SHALL be unaffected.
REQ-014 The debug unlock FSM SHALL have the states DBG_LOCKED, DBG_KEY1, DBG_OPEN and DBG_PENALTY.
REQ-015 DBG_LOCKED -> DBG_KEY1 when debug_mode=1 and dbg_key_vld=1 and dbg_key==KEY0.
REQ-016 DBG_KEY1 -> DBG_OPEN on dbg_key_vld=1 with dbg_key==KEY1.
REQ-017 DBG_KEY1 -> DBG_PENALTY on dbg_key_vld=1 with any other value.
REQ-018 DBG_LOCKED -> DBG_PENALTY on dbg_key_vld=1 with a wrong key while debug_mode=1.
REQ-019 DBG_PENALTY SHALL ignore all keys for exactly LOCKOUT_CYC cycles, then return to DBG_LOCKED.
REQ-020 debug_mode=0 SHALL force DBG_KEY1 or DBG_OPEN to DBG_LOCKED on the next edge; a PENALTY in progress SHALL run to completion.
REQ-021 Entering scan (0->1) SHALL also force the FSM to DBG_LOCKED.
REQ-022 dbg_open SHALL be 1 only in DBG_OPEN, driven directly from registered state.
REQ-023 dbg_open SHALL take effect for writes in the cycle after the state is entered.
REQ-024 While dbg_open=1, writes SHALL NOT change lock bits, except through lock_wr and lock_all, which still set them.

Reset
REQ-025 While reset is high: all registers, lock bits, rd_data, wr_err and viol_cnt SHALL be 0; the FSM SHALL be in DBG_LOCKED; dbg_open SHALL be 0.
REQ-026 Reset asserted mid-sequence (in DBG_KEY1 or DBG_PENALTY) SHALL abort the sequence immediately, with no residual penalty.

Verification
REQ-027 Basic write/lock: write 16'h1234 to addr 1, then lock_wr addr 1, then write 16'hFFFF to addr 1 -> reg1 reads 16'h1234, one wr_err pulse, viol_cnt=1.
REQ-028 Simultaneous write and lock: same-cycle wr_en and lock_wr to addr 2 with data 16'hBEEF -> reg2=16'hBEEF and lock_status[2]=1.
REQ-029 Debug unlock: debug_mode=1, keys A5C3 then 3C5A -> dbg_open=1, and a write to locked addr 1 is accepted; dropping debug_mode -> dbg_open=0 the next cycle.
REQ-030 Bad key: keys A5C3 then 0000 -> DBG_PENALTY; a correct KEY0 within 8 cycles is ignored; after 8 cycles the correct sequence opens.
REQ-031 Secure scan: with all regs nonzero, raise scan together with a write -> all regs read 0, the write is lost, locks are kept; writing a locked reg during scan -> wr_err.
REQ-032 Boundaries: NUM_REGS=3, write to addr 3 -> wr_err, rd_data=0; drive 300 violations -> viol_cnt stays at 255.
